psram_ctrl: RTL and testbench



---
 rtl/psram_pkg.sv | 40 ++++
 rtl/psram_timer.sv | 34 +++
 rtl/psram_ctrl.sv | 175 +++++++++++++++++
 tb/tb_psram_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types and constants for the asynchronous-mode PSRAM controller.
package psram_pkg;

    localparam int ADDR_W        = 23;
    localparam int DATA_W        = 16;
    localparam int T_PWRUP_DEF   = 15000;
    localparam int T_RC_DEF      = 7;
    localparam int T_REC_DEF     = 2;
    localparam int FAST_INIT_CYC = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ACC,
        ST_WR_ACC,
        ST_RECOV
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic dq_oe;
    } strb_t;

    localparam strb_t STRB_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                   ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psram_timer.sv
// Loadable down-counter shared by every controller state; saturates at zero.
module psram_timer #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= RST_VAL;
        else
            count_q <= count_d;
    end

    assign value = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/psram_ctrl.sv
// Asynchronous-mode PSRAM controller, single-word accesses with cycle-counted timing.
// Define PSRAM_CTRL_FAST_INIT_EN to shorten power-up to 16 cycles (simulation only).
module psram_ctrl
    import psram_pkg::*;
#(
    parameter int T_PWRUP = T_PWRUP_DEF,
    parameter int T_RC    = T_RC_DEF,
    parameter int T_REC   = T_REC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic              ub,
    input  logic              lb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ok,
    output logic              op_begun,
    output logic              op_finished,
    output logic              ctrlr_good,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dq_i,
    output logic [DATA_W-1:0] mem_dq_o,
    output logic              mem_dq_oe,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_ub_n,
    output logic              mem_lb_n,
    output logic              mem_adv_n,
    output logic              mem_cre,
    output logic              mem_clk
);

`ifdef PSRAM_CTRL_FAST_INIT_EN
    localparam int INIT_CYC = FAST_INIT_CYC;
`else
    localparam int INIT_CYC = T_PWRUP;
`endif
    localparam int CNT_W = $clog2(max2(max2(T_PWRUP, INIT_CYC), max2(T_RC, T_REC)) + 1);

    state_t            state_q, state_d;
    strb_t             strb_q, strb_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_ok_q, data_ok_d;
    logic              op_begun_q, op_begun_d;
    logic              op_finished_q, op_finished_d;
    logic              good_q, good_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic [CNT_W-1:0]  tmr_value;
    logic              tmr_done;

    // Loading INIT_CYC at reset makes ctrlr_good rise INIT_CYC+1 cycles after release.
    psram_timer #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(INIT_CYC))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        strb_d        = strb_q;
        req_d         = req_q;
        data_out_d    = data_out_q;
        data_ok_d     = 1'b0;
        op_begun_d    = 1'b0;
        op_finished_d = 1'b0;
        good_d        = good_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        case (state_q)
            ST_INIT: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    good_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (rd || wr) begin
                    state_d      = rd ? ST_RD_ACC : ST_WR_ACC;
                    tmr_load     = 1'b1;
                    tmr_val      = CNT_W'(T_RC - 1);
                    op_begun_d   = 1'b1;
                    req_d.addr   = addr;
                    req_d.data   = data_in;
                    strb_d.ce_n  = 1'b0;
                    strb_d.oe_n  = !rd;
                    strb_d.we_n  = rd;
                    strb_d.dq_oe = !rd;
                    strb_d.ub_n  = !ub;
                    strb_d.lb_n  = !lb;
                end
            end
            ST_RD_ACC: begin
                if (tmr_done) begin
                    state_d    = ST_RECOV;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(T_REC - 1);
                    data_out_d = mem_dq_i;
                    data_ok_d  = 1'b1;
                    strb_d     = STRB_OFF;
                end
            end
            ST_WR_ACC: begin
                // Release WE one cycle early so data is held past the write strobe.
                if (tmr_value == CNT_W'(1))
                    strb_d.we_n = 1'b1;
                if (tmr_done) begin
                    state_d  = ST_RECOV;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_REC - 1);
                    strb_d   = STRB_OFF;
                end
            end
            ST_RECOV: begin
                if (tmr_done) begin
                    state_d       = ST_IDLE;
                    op_finished_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            strb_q        <= STRB_OFF;
            req_q         <= '0;
            data_out_q    <= '0;
            data_ok_q     <= 1'b0;
            op_begun_q    <= 1'b0;
            op_finished_q <= 1'b0;
            good_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            strb_q        <= strb_d;
            req_q         <= req_d;
            data_out_q    <= data_out_d;
            data_ok_q     <= data_ok_d;
            op_begun_q    <= op_begun_d;
            op_finished_q <= op_finished_d;
            good_q        <= good_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_ok     = data_ok_q;
    assign op_begun    = op_begun_q;
    assign op_finished = op_finished_q;
    assign ctrlr_good  = good_q;
    assign mem_addr    = req_q.addr;
    assign mem_dq_o    = req_q.data;
    assign mem_dq_oe   = strb_q.dq_oe;
    assign mem_ce_n    = strb_q.ce_n;
    assign mem_oe_n    = strb_q.oe_n;
    assign mem_we_n    = strb_q.we_n;
    assign mem_ub_n    = strb_q.ub_n;
    assign mem_lb_n    = strb_q.lb_n;
    assign mem_adv_n   = 1'b0;
    assign mem_cre     = 1'b0;
    assign mem_clk     = 1'b0;

endmodule

// File: tb/tb_psram_ctrl.sv
// Directed bench for psram_ctrl: power-up, read, write, arbitration, held request, reset mid-access.
module tb_psram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, ub = 1'b0, lb = 1'b0;
    logic [22:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_ok, op_begun, op_finished, ctrlr_good;
    logic [22:0] mem_addr;
    logic [15:0] mem_dq_i = '0;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
    logic        mem_adv_n, mem_cre, mem_clk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    psram_ctrl #(.T_PWRUP(16), .T_RC(7), .T_REC(2)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .ub(ub), .lb(lb),
        .addr(addr), .data_in(data_in), .data_out(data_out), .data_ok(data_ok),
        .op_begun(op_begun), .op_finished(op_finished), .ctrlr_good(ctrlr_good),
        .mem_addr(mem_addr), .mem_dq_i(mem_dq_i), .mem_dq_o(mem_dq_o),
        .mem_dq_oe(mem_dq_oe), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n), .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n),
        .mem_adv_n(mem_adv_n), .mem_cre(mem_cre), .mem_clk(mem_clk)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if ({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n} !== 5'h1f) begin
                bad++; $display("FAIL rst_strobes k=%0d got=%b exp=11111", k, {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}); end
            total++; if ({mem_dq_oe, data_ok, op_begun, op_finished, ctrlr_good} !== 5'h0) begin
                bad++; $display("FAIL rst_flags k=%0d got=%b exp=00000", k, {mem_dq_oe, data_ok, op_begun, op_finished, ctrlr_good}); end
            total++; if ({data_out, mem_addr, mem_dq_o} !== 55'h0) begin
                bad++; $display("FAIL rst_data k=%0d got=%h exp=0", k, {data_out, mem_addr, mem_dq_o}); end
            total++; if ({mem_adv_n, mem_cre, mem_clk} !== 3'b000) begin
                bad++; $display("FAIL fixed_pins k=%0d got=%b exp=000", k, {mem_adv_n, mem_cre, mem_clk}); end
        end
    endtask

    task automatic test_power_up();
        reset = 1'b0;
        rd    = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            total++; if (ctrlr_good !== (k >= 17)) begin
                bad++; $display("FAIL pwr_good k=%0d got=%b exp=%b", k, ctrlr_good, (k >= 17)); end
            total++; if (op_begun !== (k == 18)) begin
                bad++; $display("FAIL pwr_begun k=%0d got=%b exp=%b", k, op_begun, (k == 18)); end
            if (k <= 17) begin
                total++; if ({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_dq_oe} !== 6'b111110) begin
                    bad++; $display("FAIL pwr_strobes k=%0d got=%b exp=111110", k, {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_dq_oe}); end
            end
        end
        rd = 1'b0;
        for (int k = 19; k <= 28; k++) begin
            tick();
            total++; if (op_finished !== (k == 27)) begin
                bad++; $display("FAIL pwr_fin k=%0d got=%b exp=%b", k, op_finished, (k == 27)); end
        end
    endtask

    task automatic test_read();
        rd = 1'b1; addr = 23'h012345; ub = 1'b1; lb = 1'b1; mem_dq_i = 16'h0000;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin rd = 1'b0; addr = 23'h0; end
            mem_dq_i = (k == 7) ? 16'hBEEF : 16'h0000;
            total++; if (op_begun !== (k == 1)) begin
                bad++; $display("FAIL rd_begun k=%0d got=%b exp=%b", k, op_begun, (k == 1)); end
            total++; if (mem_oe_n !== !(k <= 7) || mem_ce_n !== !(k <= 7)) begin
                bad++; $display("FAIL rd_oe_ce k=%0d got=%b%b exp=%b", k, mem_oe_n, mem_ce_n, !(k <= 7)); end
            total++; if (mem_we_n !== 1'b1 || mem_dq_oe !== 1'b0) begin
                bad++; $display("FAIL rd_we_oe k=%0d got=%b%b exp=10", k, mem_we_n, mem_dq_oe); end
            total++; if (data_ok !== (k == 8)) begin
                bad++; $display("FAIL rd_ok k=%0d got=%b exp=%b", k, data_ok, (k == 8)); end
            total++; if (op_finished !== (k == 10)) begin
                bad++; $display("FAIL rd_fin k=%0d got=%b exp=%b", k, op_finished, (k == 10)); end
            if (k >= 8) begin
                total++; if (data_out !== 16'hBEEF) begin
                    bad++; $display("FAIL rd_data k=%0d got=%h exp=beef", k, data_out); end
            end else begin
                total++; if (mem_addr !== 23'h012345 || mem_ub_n !== 1'b0 || mem_lb_n !== 1'b0) begin
                    bad++; $display("FAIL rd_addr_be k=%0d got=%h/%b%b exp=012345/00", k, mem_addr, mem_ub_n, mem_lb_n); end
            end
        end
    endtask

    task automatic test_write();
        wr = 1'b1; addr = 23'h7FFFFF; data_in = 16'hA55A; ub = 1'b1; lb = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin wr = 1'b0; addr = 23'h0; data_in = 16'h0; ub = 1'b0; lb = 1'b1; end
            total++; if (mem_we_n !== !(k <= 6)) begin
                bad++; $display("FAIL wr_we k=%0d got=%b exp=%b", k, mem_we_n, !(k <= 6)); end
            total++; if (mem_dq_oe !== (k <= 7) || mem_ce_n !== !(k <= 7) || mem_oe_n !== 1'b1) begin
                bad++; $display("FAIL wr_oe_ce k=%0d got=%b%b%b", k, mem_dq_oe, mem_ce_n, mem_oe_n); end
            total++; if (mem_ub_n !== !(k <= 7) || mem_lb_n !== 1'b1) begin
                bad++; $display("FAIL wr_be k=%0d got=%b%b exp=%b1", k, mem_ub_n, mem_lb_n, !(k <= 7)); end
            total++; if (data_ok !== 1'b0 || data_out !== 16'hBEEF) begin
                bad++; $display("FAIL wr_nook k=%0d got=%b/%h exp=0/beef", k, data_ok, data_out); end
            total++; if (op_finished !== (k == 10)) begin
                bad++; $display("FAIL wr_fin k=%0d got=%b exp=%b", k, op_finished, (k == 10)); end
            if (k <= 7) begin
                total++; if (mem_dq_o !== 16'hA55A || mem_addr !== 23'h7FFFFF) begin
                    bad++; $display("FAIL wr_data k=%0d got=%h/%h exp=a55a/7fffff", k, mem_dq_o, mem_addr); end
            end
        end
    endtask

    task automatic test_simultaneous();
        int nbeg;
        nbeg = 0;
        rd = 1'b1; wr = 1'b1; ub = 1'b1; lb = 1'b1; mem_dq_i = 16'h1357;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin rd = 1'b0; wr = 1'b0; end
            if (op_begun === 1'b1) nbeg++;
            total++; if (mem_we_n !== 1'b1 || mem_dq_oe !== 1'b0) begin
                bad++; $display("FAIL sim_we k=%0d got=%b%b exp=10", k, mem_we_n, mem_dq_oe); end
            total++; if (mem_oe_n !== !(k <= 7)) begin
                bad++; $display("FAIL sim_oe k=%0d got=%b exp=%b", k, mem_oe_n, !(k <= 7)); end
            total++; if (data_ok !== (k == 8)) begin
                bad++; $display("FAIL sim_ok k=%0d got=%b exp=%b", k, data_ok, (k == 8)); end
        end
        total++; if (nbeg !== 1) begin
            bad++; $display("FAIL sim_nbegun got=%0d exp=1", nbeg); end
        total++; if (data_out !== 16'h1357) begin
            bad++; $display("FAIL sim_data got=%h exp=1357", data_out); end
    endtask

    task automatic test_back_to_back();
        rd = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            total++; if (op_begun !== (k == 1 || k == 11)) begin
                bad++; $display("FAIL b2b_begun k=%0d got=%b exp=%b", k, op_begun, (k == 1 || k == 11)); end
            total++; if (op_finished !== (k == 10 || k == 20)) begin
                bad++; $display("FAIL b2b_fin k=%0d got=%b exp=%b", k, op_finished, (k == 10 || k == 20)); end
            if (k == 11) rd = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        wr = 1'b1; addr = 23'h000001; data_in = 16'h1234; ub = 1'b1; lb = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) wr = 1'b0;
        end
        total++; if (mem_we_n !== 1'b0 || mem_dq_oe !== 1'b1) begin
            bad++; $display("FAIL mid_pre got=%b%b exp=01", mem_we_n, mem_dq_oe); end
        reset = 1'b1;
        tick();
        total++; if (mem_ce_n !== 1'b1 || mem_we_n !== 1'b1 || mem_dq_oe !== 1'b0 || ctrlr_good !== 1'b0) begin
            bad++; $display("FAIL mid_rst got=%b%b%b%b exp=1100", mem_ce_n, mem_we_n, mem_dq_oe, ctrlr_good); end
        total++; if (mem_addr !== 23'h0 || mem_dq_o !== 16'h0 || data_out !== 16'h0) begin
            bad++; $display("FAIL mid_rst_data got=%h/%h/%h exp=0", mem_addr, mem_dq_o, data_out); end
        reset = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            tick();
            total++; if (op_finished !== 1'b0) begin
                bad++; $display("FAIL mid_nofin j=%0d got=%b exp=0", j, op_finished); end
            total++; if (ctrlr_good !== (j >= 17)) begin
                bad++; $display("FAIL mid_good j=%0d got=%b exp=%b", j, ctrlr_good, (j >= 17)); end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_read();
        test_write();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
